writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Write-back end of the MEM/WB pipeline register, and the consumer of every W-stage field it carries. The block forms the final result from the W-stage fields, including load byte/halfword extraction and sign/zero extension. It commits that result into the 32×32 integer register file and serves the two decode-stage read ports with same-cycle write-through. It also keeps a committed-write counter for debug and CPI measurement.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREG, 32, architectural register count (address width log2(NREG) = 5)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- RegWriteW  in  1  commit enable from MEM/WB
- ResultSrcW  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate
- ALUResultW  in  XLEN  ALU result; bits [1:0] are the load byte offset
- ReadDataW  in  XLEN  raw aligned word from data memory
- PCPlus4W  in  XLEN  link value for jal/jalr
- ImmExtW  in  XLEN  extended immediate for lui
- Funct3W  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- RdW  in  5  destination register
- A1D, A2D  in  5  decode-stage read addresses
- RD1D, RD2D  out  XLEN  decode-stage read data (combinational)
- ResultW  out  XLEN  final write-back value, also sent to the hazard/forwarding path
- WbCount  out  32  committed-write counter

## Operation
- Load extraction uses off = ALUResultW[1:0]:
  - lb/lbu take byte ReadDataW[8·off+7 : 8·off].
  - lh/lhu take halfword ReadDataW[16·off[1]+15 : 16·off[1]]; off[0] is ignored.
  - lw takes the whole word.
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - Unlisted Funct3W codes (011, 110, 111) behave as lw.
- ResultW is selected by ResultSrcW (00/01/10/11 as listed above). It is purely combinational.
- Commit condition: RegWriteW=1 and RdW≠0.
  - On commit, the register at RdW receives ResultW at posedge clk.
  - Writes to x0 are discarded, and x0 always reads 0.
- Read ports:
  - If the address is 0, the output is 0.
  - Otherwise, if the commit condition holds and RdW equals the address, the output is ResultW (write-through, so decode sees the value in the same cycle).
  - Otherwise, the output is the stored register value.
- WbCount increments by 1 on each posedge where the commit condition holds. It wraps from 0xFFFFFFFF to 0.

## Timing
- Asynchronous reset: all 31 stored registers and WbCount become 0 immediately. RD1D, RD2D and ResultW then follow the inputs combinationally, with stored data reading as 0.
- Reset asserted in the same cycle as a commit: reset wins, and no write and no count occur.
- Write latency: 1 edge. Read-after-write in the same cycle is 0-latency via write-through.
- Both read ports may address the same register, or RdW, simultaneously; each port resolves independently.
- No stall or flush inputs. A bubble in MEM/WB arrives as RegWriteW=0.

## Structure
- Shared package (alongside the other pipeline encodings):
  - RESULT_ALU / RESULT_MEM / RESULT_PC4 / RESULT_IMM (2-bit)
  - F3_LB / F3_LH / F3_LW / F3_LBU / F3_LHU (3-bit)
  - XLEN
- One sub-module, load_extender (Funct3W, off, ReadDataW → extended load value). It is combinational and is unit-tested separately.
- Storage is a register array of NREG-1 entries; x0 has no storage.

## Test plan
- Reset, then read A1D=5 and A2D=0 → RD1D=0, RD2D=0, WbCount=0.
- Commit with ResultSrcW=00, ALUResultW=0x1234_5678, RdW=5, and A1D=5 in the same cycle → RD1D=0x1234_5678 before the edge (write-through); after the edge it is still 0x1234_5678 with RegWriteW=0. WbCount=1.
- ReadDataW=0x80FF_7F01, ResultSrcW=01, sweeping Funct3W/offset:
  - lb off 3 → 0xFFFF_FF80
  - lbu off 3 → 0x0000_0080
  - lb off 1 → 0x0000_007F
  - lh off 2 → 0xFFFF_80FF
  - lhu off 0 → 0x0000_7F01
  - lw → 0x80FF_7F01
- RegWriteW=1, RdW=0, ResultSrcW=10, PCPlus4W=0x104 → x0 still reads 0, and WbCount is unchanged.
- Preload WbCount to 0xFFFF_FFFF via 2^32-1 commits (or force), then one more commit → WbCount=0. Assert rst mid-cycle with a commit pending → all registers read 0, and the write does not land after rst deasserts.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline encodings used by the write-back stage: result-select codes,
// load funct3 codes and the datapath width.
package writeback_regfile_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned REG_AW = $clog2(NREG);

    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10,
        RESULT_IMM = 2'b11
    } result_src_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/halfword out of an aligned load word and sign- or
// zero-extends it according to the load funct3.
module load_extender
    import writeback_regfile_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
        endcase
    end

    // Halfword loads ignore off[0]; misaligned halves are not split.
    assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        case (funct3_i)
            F3_LB:   ext_o = {{(XLEN - 8){byte_sel[7]}}, byte_sel};
            F3_LH:   ext_o = {{(XLEN - 16){half_sel[15]}}, half_sel};
            F3_LBU:  ext_o = {{(XLEN - 8){1'b0}}, byte_sel};
            F3_LHU:  ext_o = {{(XLEN - 16){1'b0}}, half_sel};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: result selection, 31-entry integer register file with
// same-cycle write-through on both decode read ports, and a commit counter.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int unsigned XLEN = writeback_regfile_pkg::XLEN,
    parameter int unsigned NREG = writeback_regfile_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [XLEN-1:0] ImmExtW,
    input  logic [2:0]      Funct3W,
    input  logic [4:0]      RdW,
    input  logic [4:0]      A1D,
    input  logic [4:0]      A2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic [31:0]     WbCount
);

    logic [XLEN-1:0] load_val;
    logic            commit;
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [31:0]     wb_count_q;
    logic [31:0]     wb_count_d;

    load_extender u_load_extender (
        .funct3_i (Funct3W),
        .off_i    (ALUResultW[1:0]),
        .rdata_i  (ReadDataW),
        .ext_o    (load_val)
    );

    always_comb begin
        unique case (ResultSrcW)
            RESULT_ALU: ResultW = ALUResultW;
            RESULT_MEM: ResultW = load_val;
            RESULT_PC4: ResultW = PCPlus4W;
            RESULT_IMM: ResultW = ImmExtW;
        endcase
    end

    assign commit = RegWriteW && (RdW != 5'd0);

    // x0 has no storage; the array starts at index 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[RdW] <= ResultW;
        end
    end

    assign wb_count_d = commit ? wb_count_q + 32'd1 : wb_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_count_q <= '0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign WbCount = wb_count_q;

    always_comb begin
        if (A1D == 5'd0) begin
            RD1D = '0;
        end else if (commit && (RdW == A1D)) begin
            RD1D = ResultW;
        end else begin
            RD1D = regs_q[A1D];
        end
    end

    always_comb begin
        if (A2D == 5'd0) begin
            RD2D = '0;
        end else if (commit && (RdW == A2D)) begin
            RD2D = ResultW;
        end else begin
            RD2D = regs_q[A2D];
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, write-through, load extraction,
// x0 handling, counter wrap and reset-versus-commit priority.
module tb_writeback_regfile;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [31:0] ImmExtW;
    logic [2:0]  Funct3W;
    logic [4:0]  RdW;
    logic [4:0]  A1D;
    logic [4:0]  A2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [31:0] WbCount;

    int n_vec;
    int n_fail;

    writeback_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .ImmExtW    (ImmExtW),
        .Funct3W    (Funct3W),
        .RdW        (RdW),
        .A1D        (A1D),
        .A2D        (A2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .ResultW    (ResultW),
        .WbCount    (WbCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic load_vec(input string tag, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] exp);
        @(negedge clk);
        Funct3W    = f3;
        ALUResultW = {30'h0000_1000, off};
        #1;
        check(tag, ResultW, exp);
    endtask

    initial begin
        n_vec      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        RegWriteW  = 1'b0;
        ResultSrcW = 2'b00;
        ALUResultW = '0;
        ReadDataW  = '0;
        PCPlus4W   = '0;
        ImmExtW    = '0;
        Funct3W    = 3'b010;
        RdW        = '0;
        A1D        = 5'd5;
        A2D        = 5'd0;

        // Reset state
        #12;
        check("rst_rd1", RD1D, 32'h0);
        check("rst_rd2", RD2D, 32'h0);
        check("rst_cnt", WbCount, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ALU commit to x5 with write-through on both ports
        @(negedge clk);
        RegWriteW  = 1'b1;
        ResultSrcW = 2'b00;
        ALUResultW = 32'h1234_5678;
        RdW        = 5'd5;
        A1D        = 5'd5;
        A2D        = 5'd5;
        #1;
        check("wt_rd1", RD1D, 32'h1234_5678);
        check("wt_rd2", RD2D, 32'h1234_5678);
        check("wt_cnt_before", WbCount, 32'h0);
        @(negedge clk);
        RegWriteW  = 1'b0;
        ALUResultW = 32'h0;
        #1;
        check("stored_rd1", RD1D, 32'h1234_5678);
        check("cnt_one", WbCount, 32'h1);

        // Load extraction sweep
        ResultSrcW = 2'b01;
        ReadDataW  = 32'h80FF_7F01;
        load_vec("lb_off3",  3'b000, 2'd3, 32'hFFFF_FF80);
        load_vec("lbu_off3", 3'b100, 2'd3, 32'h0000_0080);
        load_vec("lb_off1",  3'b000, 2'd1, 32'h0000_007F);
        load_vec("lb_off2",  3'b000, 2'd2, 32'hFFFF_FFFF);
        load_vec("lbu_off0", 3'b100, 2'd0, 32'h0000_0001);
        load_vec("lh_off2",  3'b001, 2'd2, 32'hFFFF_80FF);
        load_vec("lh_off3",  3'b001, 2'd3, 32'hFFFF_80FF);
        load_vec("lhu_off0", 3'b101, 2'd0, 32'h0000_7F01);
        load_vec("lhu_off2", 3'b101, 2'd2, 32'h0000_80FF);
        load_vec("lh_off1",  3'b001, 2'd1, 32'h0000_7F01);
        load_vec("lw",       3'b010, 2'd0, 32'h80FF_7F01);
        load_vec("f3_011",   3'b011, 2'd1, 32'h80FF_7F01);
        load_vec("f3_111",   3'b111, 2'd3, 32'h80FF_7F01);

        // Commit a signed byte load into x7, read it back on port 2
        @(negedge clk);
        Funct3W    = 3'b000;
        ALUResultW = 32'h0000_0003;
        RegWriteW  = 1'b1;
        RdW        = 5'd7;
        @(negedge clk);
        RegWriteW  = 1'b0;
        A2D        = 5'd7;
        #1;
        check("x7_lb", RD2D, 32'hFFFF_FF80);
        check("cnt_two", WbCount, 32'h2);

        // Write to x0 is dropped and not counted
        @(negedge clk);
        RegWriteW  = 1'b1;
        RdW        = 5'd0;
        ResultSrcW = 2'b10;
        PCPlus4W   = 32'h0000_0104;
        A1D        = 5'd0;
        #1;
        check("pc4_result", ResultW, 32'h0000_0104);
        check("x0_wt", RD1D, 32'h0);
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        check("x0_after", RD1D, 32'h0);
        check("x0_cnt", WbCount, 32'h2);

        // Immediate into x9, both ports on x9, then a different RdW
        @(negedge clk);
        RegWriteW  = 1'b1;
        ResultSrcW = 2'b11;
        ImmExtW    = 32'hABCD_E000;
        RdW        = 5'd9;
        A1D        = 5'd9;
        A2D        = 5'd9;
        #1;
        check("imm_rd1", RD1D, 32'hABCD_E000);
        check("imm_rd2", RD2D, 32'hABCD_E000);
        @(negedge clk);
        ImmExtW = 32'h0000_5000;
        RdW     = 5'd10;
        A2D     = 5'd10;
        #1;
        check("split_rd1", RD1D, 32'hABCD_E000);
        check("split_rd2", RD2D, 32'h0000_5000);
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        check("cnt_four", WbCount, 32'h4);

        // Counter wrap
        @(negedge clk);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        #1;
        check("cnt_preload", WbCount, 32'hFFFF_FFFF);
        @(negedge clk);
        RegWriteW  = 1'b1;
        ResultSrcW = 2'b00;
        ALUResultW = 32'h0000_0033;
        RdW        = 5'd3;
        @(negedge clk);
        RegWriteW = 1'b0;
        A1D       = 5'd3;
        #1;
        check("cnt_wrap", WbCount, 32'h0);
        check("x3_val", RD1D, 32'h0000_0033);

        // Reset during a pending commit to x5
        @(negedge clk);
        RegWriteW  = 1'b1;
        ResultSrcW = 2'b00;
        ALUResultW = 32'hDEAD_BEEF;
        RdW        = 5'd5;
        A1D        = 5'd3;
        A2D        = 5'd9;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_rd1", RD1D, 32'h0);
        check("rst_mid_rd2", RD2D, 32'h0);
        check("rst_mid_cnt", WbCount, 32'h0);
        @(negedge clk);
        RegWriteW = 1'b0;
        rst       = 1'b0;
        A1D       = 5'd5;
        A2D       = 5'd7;
        #1;
        check("rst_no_write", RD1D, 32'h0);
        check("rst_x7", RD2D, 32'h0);
        check("rst_no_count", WbCount, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
